// File: rtl/axil_spram_pkg.sv
// Shared types and constants for the AXI4-Lite to single-port RAM bridge.
package axil_spram_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_MEM  = 3'd1,
        WR_RESP = 3'd2,
        RD_MEM  = 3'd3,
        RD_WAIT = 3'd4,
        RD_RESP = 3'd5
    } bridge_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_spram_bridge_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and the RAM bridge (slave).
// Handshake: a beat transfers on a rising clk edge where valid && ready; once valid is
// raised its payload holds until that edge, and ready may depend on valid.
interface axil_spram_bridge_if #(
    parameter int AXI_AW = 32,
    parameter int DATA_W = 8
);
    logic [AXI_AW-1:0]   s_awaddr;
    logic                s_awvalid;
    logic                s_awready;
    logic [DATA_W-1:0]   s_wdata;
    logic [DATA_W/8-1:0] s_wstrb;
    logic                s_wvalid;
    logic                s_wready;
    logic [1:0]          s_bresp;
    logic                s_bvalid;
    logic                s_bready;
    logic [AXI_AW-1:0]   s_araddr;
    logic                s_arvalid;
    logic                s_arready;
    logic [DATA_W-1:0]   s_rdata;
    logic [1:0]          s_rresp;
    logic                s_rvalid;
    logic                s_rready;

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid, s_arready,
               s_rdata, s_rresp, s_rvalid
    );

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid, s_arready,
               s_rdata, s_rresp, s_rvalid
    );
endinterface

// File: rtl/axil_spram_bridge.sv
// AXI4-Lite responder turning each transaction into one single-port RAM access.
// Define AXIL_BRIDGE_ADDR_CHECK_EN to answer out-of-range addresses with SLVERR.
module axil_spram_bridge
    import axil_spram_pkg::*;
#(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 8,
    parameter int AXI_AW     = 32,
    parameter int MEM_RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    axil_spram_bridge_if.slave  s,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_din,
    input  logic [DATA_W-1:0]   mem_dout,
    output bridge_state_e       state_o
);

    localparam int OFF   = $clog2(DATA_W / 8);
    localparam int LAT_W = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;

    bridge_state_e       state_q;
    logic                aw_held_q, w_held_q, last_wr_q;
    logic [ADDR_W-1:0]   awaddr_q;
    logic                aw_err_q, rd_err_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic [LAT_W-1:0]    lat_cnt_q;
    logic                mem_en_q, mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_din_q;
    logic                bvalid_q, rvalid_q;
    logic [1:0]          bresp_q, rresp_q;
    logic [DATA_W-1:0]   rdata_q;

    logic aw_err, ar_err;
`ifdef AXIL_BRIDGE_ADDR_CHECK_EN
    assign aw_err = |(s.s_awaddr >> (OFF + ADDR_W));
    assign ar_err = |(s.s_araddr >> (OFF + ADDR_W));
`else
    logic unused_upper_bits;
    assign aw_err = 1'b0;
    assign ar_err = 1'b0;
    assign unused_upper_bits = ^{s.s_awaddr, s.s_araddr};
`endif

    logic idle, both_valid, ar_hs, aw_hs, w_hs, aw_have, w_have;
    logic [ADDR_W-1:0]   wr_addr_n;
    logic                wr_err_n;
    logic [DATA_W-1:0]   wr_data_n;
    logic [DATA_W/8-1:0] wr_strb_n;

    assign idle       = (state_q == IDLE) && !rst;
    assign both_valid = s.s_awvalid && s.s_wvalid;
    // Read may only start with nothing half-held; on an AW+W+AR collision it
    // wins only if the previous grant went to a write.
    assign s.s_arready = idle && !aw_held_q && !w_held_q && (!both_valid || last_wr_q);
    assign ar_hs       = s.s_arvalid && s.s_arready;
    assign s.s_awready = idle && !aw_held_q && !ar_hs;
    assign s.s_wready  = idle && !w_held_q && !ar_hs;
    assign aw_hs       = s.s_awvalid && s.s_awready;
    assign w_hs        = s.s_wvalid && s.s_wready;
    assign aw_have     = aw_held_q || aw_hs;
    assign w_have      = w_held_q || w_hs;

    assign wr_addr_n = aw_hs ? s.s_awaddr[OFF +: ADDR_W] : awaddr_q;
    assign wr_err_n  = aw_hs ? aw_err : aw_err_q;
    assign wr_data_n = w_hs ? s.s_wdata : wdata_q;
    assign wr_strb_n = w_hs ? s.s_wstrb : wstrb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            last_wr_q  <= 1'b0;
            awaddr_q   <= '0;
            aw_err_q   <= 1'b0;
            rd_err_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            lat_cnt_q  <= '0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (aw_hs) begin
                        aw_held_q <= 1'b1;
                        awaddr_q  <= s.s_awaddr[OFF +: ADDR_W];
                        aw_err_q  <= aw_err;
                    end
                    if (w_hs) begin
                        w_held_q <= 1'b1;
                        wdata_q  <= s.s_wdata;
                        wstrb_q  <= s.s_wstrb;
                    end
                    // Memory strobes are registered here so they appear the cycle after the grant.
                    if (aw_have && w_have) begin
                        state_q    <= WR_MEM;
                        last_wr_q  <= 1'b1;
                        mem_en_q   <= !wr_err_n;
                        mem_we_q   <= !wr_err_n && (wr_strb_n != '0);
                        mem_addr_q <= wr_addr_n;
                        mem_din_q  <= wr_data_n;
                    end else if (ar_hs) begin
                        state_q    <= RD_MEM;
                        last_wr_q  <= 1'b0;
                        rd_err_q   <= ar_err;
                        mem_en_q   <= !ar_err;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= s.s_araddr[OFF +: ADDR_W];
                    end
                end
                WR_MEM: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    bvalid_q <= 1'b1;
                    bresp_q  <= aw_err_q ? RESP_SLVERR : RESP_OKAY;
                    state_q  <= WR_RESP;
                end
                WR_RESP: begin
                    if (s.s_bready) begin
                        bvalid_q  <= 1'b0;
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                RD_MEM: begin
                    mem_en_q  <= 1'b0;
                    lat_cnt_q <= '0;
                    state_q   <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (lat_cnt_q == LAT_W'(MEM_RD_LAT - 1)) begin
                        rdata_q  <= rd_err_q ? '0 : mem_dout;
                        rresp_q  <= rd_err_q ? RESP_SLVERR : RESP_OKAY;
                        rvalid_q <= 1'b1;
                        state_q  <= RD_RESP;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + LAT_W'(1);
                    end
                end
                RD_RESP: begin
                    if (s.s_rready) begin
                        rvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s.s_bvalid = bvalid_q;
    assign s.s_bresp  = bresp_q;
    assign s.s_rvalid = rvalid_q;
    assign s.s_rresp  = rresp_q;
    assign s.s_rdata  = rdata_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign state_o    = state_q;

endmodule
